// File: rtl/fpu_sched.sv
// fpu_sched: shares one 16-bit FPU among NREQ requesters with round-robin
// arbitration. Each requester offers a whole operation (A, B, opcode). The
// winner's operands are loaded into the FPU over a serial strobe protocol,
// and the result or error comes back to that requester.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   req_valid[NREQ]     per-requester request level
//   req_a/req_b         16-bit operand slices, slice i belongs to requester i
//   req_op              2-bit opcode slices
//   req_ack[NREQ]       one-hot pulse; operands are latched in this cycle
//   resp_valid[NREQ]    one-hot completion pulse
//   resp_data           result (0 on error or timeout)
//   resp_err            FPU error or watchdog expiry
//   resp_timeout        watchdog expiry
//   busy                high from the grant cycle through the response cycle
//   fpu_data/fpu_start  FPU serial load bus and strobe
//   fpu_result/fpu_ready/fpu_error   FPU completion inputs
//
// Handshake: a requester raises req_valid with its operands and holds both
// stable until it sees req_ack; the operands are captured on the clock edge
// that ends the ack cycle. Completion is a one-cycle resp_valid pulse with
// no back-pressure. Only one operation is in flight at a time.
module fpu_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 256,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  input  logic [2*NREQ-1:0]    req_op,
  output logic [NREQ-1:0]      req_ack,
  output logic [NREQ-1:0]      resp_valid,
  output logic [15:0]          resp_data,
  output logic                 resp_err,
  output logic                 resp_timeout,
  output logic                 busy,
  output logic [15:0]          fpu_data,
  output logic                 fpu_start,
  input  logic [15:0]          fpu_result,
  input  logic                 fpu_ready,
  input  logic                 fpu_error
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_GRANT  = 4'd1;
  localparam logic [3:0] S_LD_A   = 4'd2;
  localparam logic [3:0] S_GAP_A  = 4'd3;
  localparam logic [3:0] S_LD_B   = 4'd4;
  localparam logic [3:0] S_GAP_B  = 4'd5;
  localparam logic [3:0] S_LD_OP  = 4'd6;
  localparam logic [3:0] S_GAP_OP = 4'd7;
  localparam logic [3:0] S_GO     = 4'd8;
  localparam logic [3:0] S_WAIT   = 4'd9;
  localparam logic [3:0] S_RESP   = 4'd10;

  logic [3:0]     state;
  logic [3:0]     state_nxt;
  logic [IDW-1:0] last;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] win_nxt;
  logic           any_req;
  logic [15:0]    a_q;
  logic [15:0]    b_q;
  logic [1:0]     op_q;
  logic [15:0]    res_q;
  logic           err_q;
  logic           to_q;
  logic [WDW-1:0] wdog;
  logic           wd_expired;

  // Round-robin search starting just after the last winner.
  always_comb begin
    win_nxt = last;
    any_req = 1'b0;
    for (int s = 1; s <= NREQ; s++) begin
      if (!any_req && req_valid[(int'(last) + s) % NREQ]) begin
        any_req = 1'b1;
        win_nxt = IDW'((int'(last) + s) % NREQ);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (any_req) state_nxt = S_GRANT;
      S_GRANT:  state_nxt = S_LD_A;
      S_LD_A:   state_nxt = S_GAP_A;
      S_GAP_A:  state_nxt = S_LD_B;
      S_LD_B:   state_nxt = S_GAP_B;
      S_GAP_B:  state_nxt = S_LD_OP;
      S_LD_OP:  state_nxt = S_GAP_OP;
      S_GAP_OP: state_nxt = S_GO;
      S_GO:     state_nxt = S_WAIT;
      S_WAIT:   if (fpu_error || fpu_ready || wd_expired) state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      last       <= IDW'(NREQ - 1);
      win_id     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      res_q      <= '0;
      err_q      <= 1'b0;
      to_q       <= 1'b0;
      wdog       <= '0;
      wd_expired <= 1'b0;
    end else begin
      state <= state_nxt;
      // Registered decode of the upcoming state, so busy has no input path.
      busy  <= (state_nxt != S_IDLE);
      if (state == S_IDLE && any_req) win_id <= win_nxt;
      if (state == S_GRANT) begin
        last <= win_id;
        a_q  <= req_a[win_id*16 +: 16];
        b_q  <= req_b[win_id*16 +: 16];
        op_q <= req_op[win_id*2 +: 2];
      end
      if (state == S_WAIT) begin
        // The counter is 0 in the first WAIT cycle. Expiry is registered one
        // cycle after the count reaches TIMEOUT-1, so a silent FPU gets
        // TIMEOUT+1 WAIT cycles before the forced response.
        wdog       <= wdog + 1'b1;
        wd_expired <= (wdog == WDW'(TIMEOUT - 1));
        if (fpu_error) begin
          res_q <= '0;
          err_q <= 1'b1;
          to_q  <= 1'b0;
        end else if (fpu_ready) begin
          res_q <= fpu_result;
          err_q <= 1'b0;
          to_q  <= 1'b0;
        end else if (wd_expired) begin
          res_q <= '0;
          err_q <= 1'b1;
          to_q  <= 1'b1;
        end
      end else begin
        wdog       <= '0;
        wd_expired <= 1'b0;
      end
    end
  end

  // All outputs except busy are pure decodes of the state and latched data.
  always_comb begin
    req_ack      = '0;
    resp_valid   = '0;
    resp_data    = '0;
    resp_err     = 1'b0;
    resp_timeout = 1'b0;
    fpu_start    = 1'b0;
    fpu_data     = '0;
    case (state)
      S_GRANT:  req_ack[win_id] = 1'b1;
      S_LD_A:   begin fpu_start = 1'b1; fpu_data = a_q; end
      S_GAP_A:  fpu_data = a_q;
      S_LD_B:   begin fpu_start = 1'b1; fpu_data = b_q; end
      S_GAP_B:  fpu_data = b_q;
      S_LD_OP:  begin fpu_start = 1'b1; fpu_data = {14'd0, op_q}; end
      S_GAP_OP: fpu_data = {14'd0, op_q};
      S_GO:     fpu_start = 1'b1;
      S_RESP: begin
        resp_valid[win_id] = 1'b1;
        resp_data          = res_q;
        resp_err           = err_q;
        resp_timeout       = to_q;
      end
      default: ;
    endcase
  end

endmodule
